// File: rtl/snitch_icache_refill_assembler_if.sv
// Refill-assembler bus bundle: request, beat stream, data-memory write port and completion.
interface snitch_icache_refill_assembler_if #(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned COUNT_ALIGN = 7
);
  localparam int unsigned SET_IDX_W = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;

  logic                                  req_valid_i;
  logic                                  req_ready_o;
  logic [COUNT_ALIGN-1:0]                req_addr_i;
  logic [SET_IDX_W-1:0]                  req_set_i;
  logic                                  beat_valid_i;
  logic                                  beat_ready_o;
  logic [BEAT_WIDTH-1:0]                 beat_data_i;
  logic                                  beat_error_i;
  logic [SET_COUNT-1:0]                  ram_enable_o;
  logic                                  ram_write_o;
  logic [COUNT_ALIGN-1:0]                ram_addr_o;
  logic [SET_COUNT-1:0][LINE_WIDTH-1:0]  ram_wdata_o;
  logic                                  ram_gnt_i;
  logic                                  done_valid_o;
  logic                                  done_error_o;
  logic                                  done_ready_i;

  // Refill controller / environment side
  modport master (
    output req_valid_i, req_addr_i, req_set_i,
    output beat_valid_i, beat_data_i, beat_error_i,
    output ram_gnt_i, done_ready_i,
    input  req_ready_o, beat_ready_o,
    input  ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
    input  done_valid_o, done_error_o
  );

  // Assembler side
  modport slave (
    input  req_valid_i, req_addr_i, req_set_i,
    input  beat_valid_i, beat_data_i, beat_error_i,
    input  ram_gnt_i, done_ready_i,
    output req_ready_o, beat_ready_o,
    output ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
    output done_valid_o, done_error_o
  );
endinterface

// File: rtl/snitch_icache_refill_assembler.sv
// Assembles refill beats into one icache line and writes it to the selected set.
// Optional macro SNITCH_ICACHE_REFILL_ERR_EN: errored lines skip the write and report done_error_o.
module snitch_icache_refill_assembler #(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned COUNT_ALIGN = 7
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  snitch_icache_refill_assembler_if.slave bus
);
  localparam int unsigned BEATS     = (LINE_WIDTH / BEAT_WIDTH > 0) ? LINE_WIDTH / BEAT_WIDTH : 1;
  localparam int unsigned SET_IDX_W = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COUNT_ALIGN-1:0] addr_q, addr_d;
  logic [SET_IDX_W-1:0]   set_q, set_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic                   err_q, err_d;

  logic                   req_ready_q, req_ready_d;
  logic                   beat_ready_q, beat_ready_d;
  logic                   ram_write_q, ram_write_d;
  logic [SET_COUNT-1:0]   ram_enable_q, ram_enable_d;
  logic [COUNT_ALIGN-1:0] ram_addr_q, ram_addr_d;
  logic [LINE_WIDTH-1:0]  ram_line_q, ram_line_d;
  logic                   done_valid_q, done_valid_d;
  logic                   done_error_q, done_error_d;

  // Next state, datapath and output decode of the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    set_d   = set_q;
    line_d  = line_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          set_d   = bus.req_set_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.beat_valid_i) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = bus.beat_data_i;
          end
`ifdef SNITCH_ICACHE_REFILL_ERR_EN
          err_d = err_q | bus.beat_error_i;
`endif
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = err_d ? DONE : WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (bus.ram_gnt_i) state_d = DONE;
      end
      DONE: begin
        if (bus.done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    beat_ready_d = (state_d == FILL);
    ram_write_d  = (state_d == WRITE);
    ram_enable_d = ram_write_d ? (SET_COUNT'(1) << set_d) : '0;
    ram_addr_d   = ram_write_d ? addr_d : '0;
    ram_line_d   = ram_write_d ? line_d : '0;
    done_valid_d = (state_d == DONE);
    done_error_d = done_valid_d & err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      set_q        <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      beat_ready_q <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_enable_q <= '0;
      ram_addr_q   <= '0;
      ram_line_q   <= '0;
      done_valid_q <= 1'b0;
      done_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      set_q        <= set_d;
      line_q       <= line_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      beat_ready_q <= beat_ready_d;
      ram_write_q  <= ram_write_d;
      ram_enable_q <= ram_enable_d;
      ram_addr_q   <= ram_addr_d;
      ram_line_q   <= ram_line_d;
      done_valid_q <= done_valid_d;
      done_error_q <= done_error_d;
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.beat_ready_o = beat_ready_q;
  assign bus.ram_write_o  = ram_write_q;
  assign bus.ram_enable_o = ram_enable_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_wdata_o  = {SET_COUNT{ram_line_q}};
  assign bus.done_valid_o = done_valid_q;

`ifdef SNITCH_ICACHE_REFILL_ERR_EN
  assign bus.done_error_o = done_error_q;
`else
  // Error reporting compiled out: the flag stays constant and the beat error bit is dropped.
  logic unused_err;
  assign unused_err       = bus.beat_error_i | done_error_q;
  assign bus.done_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_icache_refill_assembler.sv
// Directed bench for snitch_icache_refill_assembler (BEATS = 2, 4 sets).
module tb_snitch_icache_refill_assembler;
  localparam int unsigned LW = 128;
  localparam int unsigned BW = 64;
  localparam int unsigned SC = 4;
  localparam int unsigned CA = 7;

  typedef struct packed {
    logic          req_valid;
    logic [6:0]    addr;
    logic [1:0]    set;
    logic          beat_valid;
    logic [63:0]   data;
    logic          beat_err;
    logic          gnt;
    logic          done_ready;
  } in_t;

  typedef struct packed {
    logic          req_ready;
    logic          beat_ready;
    logic          ram_write;
    logic [3:0]    en;
    logic [6:0]    addr;
    logic [127:0]  line;
    logic          done_valid;
    logic          done_error;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  always #5 clk = ~clk;

  snitch_icache_refill_assembler_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .SET_COUNT(SC), .COUNT_ALIGN(CA)) bus ();

  snitch_icache_refill_assembler #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .SET_COUNT(SC), .COUNT_ALIGN(CA)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Granted data-memory writes
  always @(posedge clk) begin
    if (!rst && bus.ram_write_o && bus.ram_gnt_i) wr_count <= wr_count + 1;
  end

  function automatic in_t mk_in(logic rv, logic [6:0] a, logic [1:0] s, logic bv,
                                logic [63:0] d, logic be, logic g, logic dr);
    in_t r;
    r.req_valid = rv; r.addr = a; r.set = s; r.beat_valid = bv;
    r.data = d; r.beat_err = be; r.gnt = g; r.done_ready = dr;
    return r;
  endfunction

  function automatic in_t i_none();                         return mk_in(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t i_req(logic [6:0] a, logic [1:0] s); return mk_in(1, a, s, 0, 0, 0, 0, 0); endfunction
  function automatic in_t i_beat(logic [63:0] d, logic e);  return mk_in(0, 0, 0, 1, d, e, 0, 0); endfunction
  function automatic in_t i_gnt();                          return mk_in(0, 0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic in_t i_dr();                           return mk_in(0, 0, 0, 0, 0, 0, 0, 1); endfunction

  function automatic out_t o_base();
    out_t o;
    o = '0;
    return o;
  endfunction
  function automatic out_t o_idle(); out_t o = o_base(); o.req_ready = 1'b1;  return o; endfunction
  function automatic out_t o_fill(); out_t o = o_base(); o.beat_ready = 1'b1; return o; endfunction
  function automatic out_t o_write(logic [3:0] en, logic [6:0] a, logic [127:0] l);
    out_t o = o_base();
    o.ram_write = 1'b1; o.en = en; o.addr = a; o.line = l;
    return o;
  endfunction
  function automatic out_t o_done(logic err);
    out_t o = o_base();
    o.done_valid = 1'b1; o.done_error = err;
    return o;
  endfunction

  task automatic apply(input in_t i);
    bus.req_valid_i  = i.req_valid;
    bus.req_addr_i   = i.addr;
    bus.req_set_i    = i.set;
    bus.beat_valid_i = i.beat_valid;
    bus.beat_data_i  = i.data;
    bus.beat_error_i = i.beat_err;
    bus.ram_gnt_i    = i.gnt;
    bus.done_ready_i = i.done_ready;
  endtask

  task automatic check(input string nm, input out_t e);
    out_t a;
    a.req_ready  = bus.req_ready_o;
    a.beat_ready = bus.beat_ready_o;
    a.ram_write  = bus.ram_write_o;
    a.en         = bus.ram_enable_o;
    a.addr       = bus.ram_addr_o;
    a.line       = bus.ram_wdata_o[0];
    a.done_valid = bus.done_valid_o;
    a.done_error = bus.done_error_o;
    checks++;
    if (a !== e || bus.ram_wdata_o !== {SC{e.line}}) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Outputs are registered, so the expectation describes the cycle in which the inputs are applied
  task automatic step(input string nm, input in_t i, input out_t e);
    apply(i);
    check(nm, e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    logic [63:0] b0, b1, c0, c1, d0, d1, jj, e0, e1, f0, f1, g0, g1, h0, i0, i1;
    int w0, cyc;

    b0 = 64'h1111_2222_3333_4444; b1 = 64'hAAAA_BBBB_CCCC_DDDD;
    c0 = 64'h0123_4567_89AB_CDEF; c1 = 64'hFEDC_BA98_7654_3210;
    d0 = 64'h5555_0000_5555_0000; d1 = 64'h0000_AAAA_0000_AAAA;
    jj = 64'h7777_6666_5555_4444;
    e0 = 64'hE0E0_E0E0_0000_0001; e1 = 64'hE1E1_E1E1_0000_0002;
    f0 = 64'hF0F0_0000_F0F0_0000; f1 = 64'h0F0F_0F0F_1234_5678;
    g0 = 64'h9999_8888_7777_6666; g1 = 64'h1212_3434_5656_7878;
    h0 = 64'hDEAD_BEEF_DEAD_BEEF;
    i0 = 64'h0BAD_F00D_0000_1111; i1 = 64'hCAFE_BABE_2222_3333;

    // Basic refill, then illegal traffic while busy
    tv.push_back('{i_req(7'h05, 2'd2), o_idle()});
    tv.push_back('{i_beat(b0, 0), o_fill()});
    tv.push_back('{i_beat(b1, 0), o_fill()});
    tv.push_back('{i_gnt(), o_write(4'b0100, 7'h05, {b1, b0})});
    tv.push_back('{i_dr(), o_done(0)});
    tv.push_back('{i_none(), o_idle()});
    tv.push_back('{mk_in(0, 7'h00, 2'd0, 1, h0, 0, 0, 0), o_idle()});
    tv.push_back('{mk_in(1, 7'h7F, 2'd3, 1, h0, 0, 0, 0), o_idle()});
    tv.push_back('{mk_in(1, 7'h11, 2'd0, 1, c0, 0, 0, 0), o_fill()});
    tv.push_back('{mk_in(1, 7'h11, 2'd0, 1, c1, 0, 0, 0), o_fill()});
    tv.push_back('{mk_in(1, 7'h11, 2'd0, 0, 0, 0, 1, 0), o_write(4'b1000, 7'h7F, {c1, c0})});
    tv.push_back('{mk_in(1, 7'h11, 2'd0, 0, 0, 0, 0, 1), o_done(0)});
    tv.push_back('{i_req(7'h11, 2'd0), o_idle()});
    tv.push_back('{i_beat(d0, 0), o_fill()});
    tv.push_back('{i_beat(d1, 0), o_fill()});
    tv.push_back('{i_gnt(), o_write(4'b0001, 7'h11, {d1, d0})});
    tv.push_back('{i_dr(), o_done(0)});
    tv.push_back('{i_none(), o_idle()});

    apply(i_none());
    repeat (3) @(negedge clk);
    check("reset", o_idle());
    rst = 1'b0;

    foreach (tv[k]) step($sformatf("vec%0d", k), tv[k].i, tv[k].e);
    check_int("table_writes", wr_count, 3);

    // Request acceptance cycle counts as cycle 1; done_valid expected in cycle BEATS+3
    apply(i_req(7'h20, 2'd1));
    check("lat_accept", o_idle());
    @(negedge clk);
    cyc = 2;
    apply(mk_in(0, 0, 0, 1, jj, 0, 1, 0));
    while (!bus.done_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_int("latency", cyc, 5);
    step("lat_done", i_dr(), o_done(0));
    step("lat_idle", i_none(), o_idle());

    // Grant stall: six ungranted cycles with stable outputs, one granted write
    w0 = wr_count;
    step("gs_req", i_req(7'h2A, 2'd1), o_idle());
    step("gs_b0", i_beat(e0, 0), o_fill());
    step("gs_b1", i_beat(e1, 0), o_fill());
    for (int k = 0; k < 6; k++) step($sformatf("gs_stall%0d", k), i_none(), o_write(4'b0010, 7'h2A, {e1, e0}));
    step("gs_gnt", i_gnt(), o_write(4'b0010, 7'h2A, {e1, e0}));
    step("gs_done", i_none(), o_done(0));
    step("gs_done_rd", i_dr(), o_done(0));
    step("gs_idle", i_none(), o_idle());
    check_int("gs_writes", wr_count - w0, 1);

    // Gapped beats and held-off completion
    step("bp_req", i_req(7'h33, 2'd3), o_idle());
    step("bp_b0", i_beat(f0, 0), o_fill());
    step("bp_gap0", i_none(), o_fill());
    step("bp_gap1", i_none(), o_fill());
    step("bp_b1", i_beat(f1, 0), o_fill());
    step("bp_wr", i_gnt(), o_write(4'b1000, 7'h33, {f1, f0}));
    for (int k = 0; k < 3; k++) step($sformatf("bp_hold%0d", k), i_none(), o_done(0));
    step("bp_done", i_dr(), o_done(0));
    step("bp_idle", i_none(), o_idle());

    // Error on beat 0
    w0 = wr_count;
    step("er_req", i_req(7'h0F, 2'd1), o_idle());
    step("er_b0", i_beat(g0, 1), o_fill());
    step("er_b1", mk_in(0, 0, 0, 1, g1, 0, 1, 0), o_fill());
`ifdef SNITCH_ICACHE_REFILL_ERR_EN
    step("er_done", mk_in(0, 0, 0, 0, 0, 0, 1, 1), o_done(1));
    step("er_idle", i_none(), o_idle());
    check_int("er_writes", wr_count - w0, 0);
`else
    step("er_wr", i_gnt(), o_write(4'b0010, 7'h0F, {g1, g0}));
    step("er_done", i_dr(), o_done(0));
    step("er_idle", i_none(), o_idle());
    check_int("er_writes", wr_count - w0, 1);
`endif

    // Reset after beat 0 abandons the line; next request completes normally
    w0 = wr_count;
    step("rs_req", i_req(7'h44, 2'd0), o_idle());
    step("rs_b0", i_beat(h0, 0), o_fill());
    apply(mk_in(0, 0, 0, 0, 0, 0, 1, 1));
    rst = 1'b1;
    check("rs_pre", o_fill());
    @(negedge clk);
    check("rs_out", o_idle());
    rst = 1'b0;
    check_int("rs_writes", wr_count - w0, 0);
    step("rs2_req", i_req(7'h45, 2'd0), o_idle());
    step("rs2_b0", i_beat(i0, 0), o_fill());
    step("rs2_b1", i_beat(i1, 0), o_fill());
    step("rs2_wr", i_gnt(), o_write(4'b0001, 7'h45, {i1, i0}));
    step("rs2_done", i_dr(), o_done(0));
    step("rs2_idle", i_none(), o_idle());
    check_int("rs2_writes", wr_count - w0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snitch_icache_refill_assembler.md
# snitch_icache_refill_assembler

- Collects refill beats returned from the L0/L1 refill path into one full cache line, then issues a single write to the selected set of the instruction-cache data memory.
- Sits directly upstream of the icache data memory write port; the lookup read path shares that port through `ram_gnt_i`.
- Reports completion, and optionally a bus error, back to the refill controller.

## Interface
Parameters:
- `LINE_WIDTH`, 128: cache line width in bits; must be a multiple of `BEAT_WIDTH`.
- `BEAT_WIDTH`, 64: refill beat width in bits.
- `SET_COUNT`, 4: number of cache sets (ways).
- `COUNT_ALIGN`, 7: line-index address width.
- `BEATS`, derived, `LINE_WIDTH/BEAT_WIDTH`, at least 1.
- `SET_IDX_W`, derived, `max(1, $clog2(SET_COUNT))`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  refill request valid.
- `req_ready_o`  out  1  request accepted.
- `req_addr_i`  in  `COUNT_ALIGN`  target line index.
- `req_set_i`  in  `SET_IDX_W`  target set.
- `beat_valid_i`  in  1  beat valid.
- `beat_ready_o`  out  1  beat accepted.
- `beat_data_i`  in  `BEAT_WIDTH`  beat payload.
- `beat_error_i`  in  1  beat carries a bus error.
- `ram_enable_o`  out  `SET_COUNT`  one-hot set enable.
- `ram_write_o`  out  1  write strobe.
- `ram_addr_o`  out  `COUNT_ALIGN`  write line index.
- `ram_wdata_o`  out  `SET_COUNT x LINE_WIDTH`  assembled line, replicated to every set.
- `ram_gnt_i`  in  1  data-memory write port granted this cycle.
- `done_valid_o`  out  1  refill finished.
- `done_error_o`  out  1  finished line had an error.
- `done_ready_i`  in  1  completion consumed.

## Operation
The FSM has four states: IDLE, FILL, WRITE, DONE.

- **IDLE**
  - `req_ready_o = 1`.
  - On `req_valid_i`: latch address and set, clear the beat counter and error flag, then go to FILL.
- **FILL**
  - `beat_ready_o = 1`.
  - Each beat handshake writes `beat_data_i` to line bits `[cnt*BEAT_WIDTH +: BEAT_WIDTH]`, so beat 0 fills the LSBs.
  - Each handshake increments `cnt` and ORs `beat_error_i` into the sticky error flag.
  - The handshake with `cnt == BEATS-1` moves to WRITE, or to DONE if the line is suppressed (see Configuration).
- **WRITE**
  - `ram_write_o = 1`.
  - `ram_enable_o = 1 << set`.
  - Address and data are held stable until `ram_gnt_i = 1`; the write is complete in that cycle, and the FSM goes to DONE.
- **DONE**
  - `done_valid_o = 1`, with `done_error_o` equal to the error flag.
  - On `done_ready_i`, go to IDLE.
- All other outputs are 0 outside their own state. In particular, `ram_enable_o` and `ram_write_o` are 0 whenever the FSM is not in WRITE.
- The beat counter is `$clog2(BEATS)` bits wide, minimum 1. It is cleared on request acceptance and never wraps inside a line.

## Timing
- Reset forces IDLE and clears the counter, error flag, line register, latched address and latched set.
- Reset values of the outputs:
  - `req_ready_o = 1`.
  - `beat_ready_o = 0`, `ram_enable_o = 0`, `ram_write_o = 0`, `ram_addr_o = 0`, `ram_wdata_o = 0`.
  - `done_valid_o = 0`, `done_error_o = 0`.
- All outputs are registered-state decodes; there is no combinational path from any input to any output.
- Request accept to first `beat_ready_o`: 1 cycle.
- Last beat handshake to `ram_write_o`: 1 cycle.
- With `ram_gnt_i` tied high, an uninterrupted refill from request to `done_valid_o` takes `BEATS + 3` cycles.
- While in WRITE with `ram_gnt_i = 0`, the block stalls indefinitely with outputs stable.
- `beat_valid_i` in IDLE, WRITE or DONE is not accepted (`beat_ready_o = 0`).
- `req_valid_i` outside IDLE is not accepted (`req_ready_o = 0`).
- Reset asserted in any state abandons the operation: no write is issued and no completion is reported.

## Configuration
Macro: `SNITCH_ICACHE_REFILL_ERR_EN`.

- **Defined:**
  - A line with any errored beat skips WRITE and goes from FILL straight to DONE.
  - The data memory is never written for such a line, and `done_error_o = 1` accompanies `done_valid_o`.
- **Undefined:**
  - `beat_error_i` is ignored, no error flag is built, and every line is written.
  - `done_error_o` is tied to 0.

## Test plan
- Basic refill (`BEATS = 2`, `ram_gnt_i = 1`): request addr 0x05, set 2; beats 0x1111_2222_3333_4444 then 0xAAAA_BBBB_CCCC_DDDD.
  - Expected: one write cycle with `ram_enable_o = 4'b0100`, `ram_addr_o = 0x05`, `ram_wdata_o[2] = {beat1, beat0}`.
  - Expected: `done_valid_o` 5 cycles after request acceptance.
- Grant stall: hold `ram_gnt_i = 0` for 6 cycles in WRITE.
  - Expected: enable, address and data are stable throughout; exactly one granted write; then DONE.
- Backpressure: `beat_valid_i` is gapped (valid, idle, idle, valid) and `done_ready_i` is held low for 3 cycles.
  - Expected: line assembles correctly; `done_valid_o` stays high until `done_ready_i` is asserted.
- Error with macro defined: `beat_error_i = 1` on beat 0.
  - Expected: `ram_write_o` never asserts; `done_error_o = 1`.
  - Without the macro: the same stimulus produces the write and `done_error_o = 0`.
- Reset mid-FILL: assert `rst_i` after beat 0.
  - Expected: outputs return to reset values the next cycle; no write occurs.
  - Expected: a following request completes normally.
- Illegal traffic: `req_valid_i` held high during FILL and `beat_valid_i` held high during IDLE.
  - Expected: neither is accepted; only the second request starts after DONE.
